// File: rtl/mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mac_operand_sequencer
//
// Drives one MAC unit through a complete N-element dot product. Operand pairs
// are read from two synchronous-read buffers (A feeds MAC w, B feeds MAC x).
// The MAC accumulator is cleared first. The pairs are then streamed, with
// mac_load timed to the MAC's registered multiplier and its negedge
// accumulator. The final sum is captured and offered on a valid/ready port.
//
// Sequence: IDLE -> CLR -> RUN (N cycles) -> DRAIN -> OUT -> IDLE
//
// Ports
//   clk        clock, all state changes on posedge
//   clr        synchronous active-high reset; also clears the MAC accumulator
//   start      begin a dot product (sampled in IDLE only)
//   busy       high in every state except IDLE
//   a_addr     operand buffer A read address
//   b_addr     operand buffer B read address (always equal to a_addr)
//   a_rdata    A read data, valid the cycle after the address
//   b_rdata    B read data, same latency as A
//   mac_w      MAC w operand (a_rdata during RUN, else 0)
//   mac_x      MAC x operand (b_rdata during RUN, else 0)
//   mac_load   MAC accumulate enable
//   mac_clear  MAC accumulator clear
//   mac_o      MAC accumulator output
//   res_data   captured dot product
//   res_valid  result available
//   res_ready  result consumer accepts
// -----------------------------------------------------------------------------
module mac_operand_sequencer #(
  parameter int N      = 4,
  parameter int DW     = 4,
  parameter int RW     = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DW-1:0]     a_rdata,
  input  logic [DW-1:0]     b_rdata,
  output logic [DW-1:0]     mac_w,
  output logic [DW-1:0]     mac_x,
  output logic              mac_load,
  output logic              mac_clear,
  input  logic [RW-1:0]     mac_o,
  output logic [RW-1:0]     res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   addr;
  logic                busy_q;
  logic                load_q;
  logic                clr_q;

  // Address increment that wraps at N (N need not be a power of two).
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] i);
    if (i == LAST) return '0;
    else           return i + ADDR_W'(1);
  endfunction

  // The buffers have one cycle of read latency, so the address always runs one
  // element ahead of idx: element 0 is addressed in CLR, and element i+1 is
  // addressed in RUN i.
  //
  // mac_load is registered. It is set on entry to RUN idx>0 and to DRAIN.
  // The MAC registers pair i at the posedge ending RUN i and accumulates it at
  // the negedge of the following cycle. RUN 0 therefore never loads (its
  // product register holds the zero fed during CLR), and DRAIN picks up the
  // last pair.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      idx       <= '0;
      addr      <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          load_q <= 1'b0;
          addr   <= '0;
          if (start) begin
            state  <= S_CLR;
            busy_q <= 1'b1;
            clr_q  <= 1'b1;
          end
        end

        S_CLR: begin
          state  <= S_RUN;
          idx    <= '0;
          addr   <= wrap_inc('0);
          clr_q  <= 1'b0;
          load_q <= 1'b0;
        end

        S_RUN: begin
          if (idx == LAST) begin
            state  <= S_DRAIN;
            addr   <= '0;
            load_q <= 1'b1;
          end else begin
            idx    <= idx + ADDR_W'(1);
            addr   <= wrap_inc(addr);
            load_q <= 1'b1;
          end
        end

        // The last pair is added at this cycle's negedge, so mac_o is final
        // at the posedge that ends DRAIN.
        S_DRAIN: begin
          state     <= S_OUT;
          idx       <= '0;
          load_q    <= 1'b0;
          res_data  <= mac_o;
          res_valid <= 1'b1;
        end

        S_OUT: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            busy_q    <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          idx       <= '0;
          addr      <= '0;
          res_valid <= 1'b0;
          busy_q    <= 1'b0;
          load_q    <= 1'b0;
          clr_q     <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign a_addr   = addr;
  assign b_addr   = addr;
  assign mac_load = load_q;

  // The MAC has no reset of its own, so the block reset is forwarded to it
  // combinationally. This clears the accumulator at the negedge inside the
  // reset cycle.
  assign mac_clear = clr | clr_q;

  // Operands are forced to zero outside RUN. A stale product can then never
  // reach the accumulator, even if the MAC's load timing were looser than
  // assumed.
  always_comb begin
    mac_w = '0;
    mac_x = '0;
    if (state == S_RUN) begin
      mac_w = a_rdata;
      mac_x = b_rdata;
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int RW = 8;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N=4 instance ----------------
  logic          clr, start, busy, mac_load, mac_clear, res_valid, res_ready;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_rdata, b_rdata, mac_w, mac_x;
  logic [RW-1:0] mac_o, res_data;
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  logic [2*DW-1:0] prod;
  logic [RW-1:0]   acc;

  mac_operand_sequencer #(.N(N), .DW(DW), .RW(RW), .ADDR_W(AW)) dut (
    .clk(clk), .clr(clr), .start(start), .busy(busy),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mac_w(mac_w), .mac_x(mac_x), .mac_load(mac_load), .mac_clear(mac_clear),
    .mac_o(mac_o), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
  end

  // MAC model: registered multiplier, negedge accumulator, clear has priority.
  always @(posedge clk) prod <= {4'b0, mac_w} * {4'b0, mac_x};
  always @(negedge clk) begin
    if (mac_clear)     acc <= '0;
    else if (mac_load) acc <= acc + prod;
  end
  assign mac_o = acc;

  // ---------------- N=1 instance ----------------
  logic          start1, busy1, load1, clear1, valid1, ready1;
  logic [0:0]    a1_addr, b1_addr;
  logic [DW-1:0] a1_rdata, b1_rdata, w1, x1, m1a, m1b;
  logic [RW-1:0] o1, res1;
  logic [2*DW-1:0] prod1;
  logic [RW-1:0]   acc1;

  mac_operand_sequencer #(.N(1), .DW(DW), .RW(RW), .ADDR_W(1)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .busy(busy1),
    .a_addr(a1_addr), .b_addr(b1_addr), .a_rdata(a1_rdata), .b_rdata(b1_rdata),
    .mac_w(w1), .mac_x(x1), .mac_load(load1), .mac_clear(clear1),
    .mac_o(o1), .res_data(res1), .res_valid(valid1), .res_ready(ready1)
  );

  always @(posedge clk) begin
    a1_rdata <= (a1_addr == 1'b0) ? m1a : '0;
    b1_rdata <= (b1_addr == 1'b0) ? m1b : '0;
    prod1    <= {4'b0, w1} * {4'b0, x1};
  end
  always @(negedge clk) begin
    if (clear1)     acc1 <= '0;
    else if (load1) acc1 <= acc1 + prod1;
  end
  assign o1 = acc1;

  // ---------------- checking ----------------
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0][3:0] a;
    logic [3:0][3:0] b;
    logic [7:0]      res;
    int              hold;
    string           tag;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int cyc, loads, addr_err, run_err, drain_err, hold_err;
    for (int i = 0; i < N; i++) begin
      mem_a[i] = v.a[i];
      mem_b[i] = v.b[i];
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk({v.tag, "_clr_busy"}, {30'd0, mac_clear, busy}, 32'd3);
    cyc = 1; loads = 0; addr_err = 0; run_err = 0; drain_err = 0; hold_err = 0;
    while (!res_valid && cyc < 40) begin
      if (mac_load) loads++;
      if (a_addr !== b_addr) addr_err++;
      if (cyc == 1 && a_addr !== '0) addr_err++;
      if (cyc >= 2 && cyc <= N + 1) begin
        if (a_addr !== AW'((cyc - 1) % N)) addr_err++;
        if (mac_w !== v.a[cyc-2] || mac_x !== v.b[cyc-2]) run_err++;
        if (cyc == 2 && mac_load !== 1'b0) run_err++;
      end
      if (cyc == N + 2 && (mac_w !== '0 || mac_x !== '0 || mac_load !== 1'b1)) drain_err++;
      step();
      cyc++;
    end
    chk({v.tag, "_latency"}, cyc, N + 3);
    chk({v.tag, "_loads"}, loads, N);
    chk({v.tag, "_addr"}, addr_err, 0);
    chk({v.tag, "_operands"}, run_err, 0);
    chk({v.tag, "_drain"}, drain_err, 0);
    chk({v.tag, "_res_data"}, {24'd0, res_data}, {24'd0, v.res});
    chk({v.tag, "_out_busy"}, {31'd0, busy}, 32'd1);
    for (int k = 0; k < v.hold; k++) begin
      start = (k == 3);
      step();
      if (res_valid !== 1'b1 || res_data !== v.res || busy !== 1'b1) hold_err++;
    end
    start = 1'b0;
    if (v.hold > 0) chk({v.tag, "_hold_stable"}, hold_err, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({v.tag, "_ack"}, {30'd0, busy, res_valid}, 32'd0);
    step();
    chk({v.tag, "_idle_after"}, {30'd0, busy, res_valid}, 32'd0);
  endtask

  initial begin
    int cyc, loads, seen;

    vecs[0] = '{a: {4'd4, 4'd3, 4'd2, 4'd1}, b: {4'd8, 4'd7, 4'd6, 4'd5},
                res: 8'd70, hold: 0, tag: "v_1234"};
    vecs[1] = '{a: {4'd15, 4'd15, 4'd15, 4'd15}, b: {4'd15, 4'd15, 4'd15, 4'd15},
                res: 8'd132, hold: 0, tag: "v_wrap"};
    vecs[2] = '{a: {4'd2, 4'd15, 4'd0, 4'd3}, b: {4'd8, 4'd1, 4'd7, 4'd4},
                res: 8'd43, hold: 10, tag: "v_hold"};
    vecs[3] = '{a: {4'd12, 4'd13, 4'd14, 4'd15}, b: {4'd4, 4'd3, 4'd2, 4'd1},
                res: 8'd130, hold: 0, tag: "v_desc"};
    vecs[4] = '{a: {4'd1, 4'd1, 4'd1, 4'd1}, b: {4'd2, 4'd2, 4'd2, 4'd2},
                res: 8'd8, hold: 0, tag: "v_b2b_1"};
    vecs[5] = '{a: {4'd0, 4'd0, 4'd0, 4'd0}, b: {4'd9, 4'd9, 4'd9, 4'd9},
                res: 8'd0, hold: 0, tag: "v_b2b_0"};

    for (int i = 0; i < N; i++) begin
      mem_a[i] = 4'd5;
      mem_b[i] = 4'd6;
    end
    m1a = 4'd7; m1b = 4'd3;
    res_ready = 1'b0; ready1 = 1'b0; start1 = 1'b0;

    // Reset, with start asserted alongside clr.
    clr = 1'b1; start = 1'b1;
    step();
    step();
    chk("rst_mac_clear", {31'd0, mac_clear}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid_data", {23'd0, res_valid, res_data}, 32'd0);
    chk("rst_addr", {30'd0, a_addr}, 32'd0);
    chk("rst_load_ops", {23'd0, mac_load, mac_w, mac_x}, 32'd0);
    clr = 1'b0; start = 1'b0;
    step();
    chk("clr_wins_start", {30'd0, busy, busy1}, 32'd0);
    chk("idle_no_clear", {31'd0, mac_clear}, 32'd0);

    // Abort mid-run: clr during RUN idx=2 (cycle 4).
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 4'd15;
      mem_b[i] = 4'd15;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    clr = 1'b1;
    #1;
    chk("abort_mac_clear", {31'd0, mac_clear}, 32'd1);
    step();
    clr = 1'b0;
    chk("abort_idle", {30'd0, busy, res_valid}, 32'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("abort_no_result", seen, 0);

    // Table-driven runs.
    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // N=1 build.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    cyc = 1; loads = 0;
    while (!valid1 && cyc < 20) begin
      if (load1) loads++;
      step();
      cyc++;
    end
    chk("n1_latency", cyc, 4);
    chk("n1_loads", loads, 1);
    chk("n1_res_data", {24'd0, res1}, 32'd21);
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    chk("n1_ack", {30'd0, busy1, valid1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
